lif_neuron: RTL and testbench

LIF_NEURON -- requirements
Module: lif_neuron

---
 rtl/snn_pkg.sv | 17 +
 rtl/lif_sat_add.sv | 35 +++
 rtl/lif_neuron.sv | 113 +++++++++++
 tb/tb_lif_neuron.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared FSM encoding and default constants for the spiking-neuron blocks.
package snn_pkg;

  typedef enum logic {
    ST_INTEG   = 1'b0,
    ST_REFRACT = 1'b1
  } lif_state_e;

  localparam int DEF_WIDTH         = 8;
  localparam int DEF_POT_WIDTH     = 12;
  localparam int DEF_THRESH        = 64;
  localparam int DEF_LEAK_SHIFT    = 3;
  localparam int DEF_V_FLOOR       = -128;
  localparam int DEF_REFRACT_STEPS = 2;
  localparam int CNT_WIDTH         = 4;

endpackage

// File: rtl/lif_sat_add.sv
// Combinational leak-subtract, sign-extended add and clamp of the membrane potential.
module lif_sat_add #(
  parameter int WIDTH      = snn_pkg::DEF_WIDTH,
  parameter int POT_WIDTH  = snn_pkg::DEF_POT_WIDTH,
  parameter int LEAK_SHIFT = snn_pkg::DEF_LEAK_SHIFT,
  parameter int V_FLOOR    = snn_pkg::DEF_V_FLOOR
) (
  input  logic signed [POT_WIDTH-1:0] v_i,
  input  logic signed [WIDTH-1:0]     sum_i,
  output logic signed [POT_WIDTH-1:0] v_o
);

  localparam int EW = POT_WIDTH + 2;

  // Two guard bits keep V - leak + sum from wrapping before the clamp sees it.
  localparam logic signed [EW-1:0] V_MAX = {3'b000, {(POT_WIDTH-1){1'b1}}};
  localparam logic signed [EW-1:0] V_MIN = EW'(V_FLOOR);

  logic signed [EW-1:0] v_ext;
  logic signed [EW-1:0] sum_ext;
  logic signed [EW-1:0] leak;
  logic signed [EW-1:0] raw;

  assign v_ext   = {{2{v_i[POT_WIDTH-1]}}, v_i};
  assign sum_ext = {{(EW-WIDTH){sum_i[WIDTH-1]}}, sum_i};
  assign leak    = v_ext >>> LEAK_SHIFT;
  assign raw     = v_ext - leak + sum_ext;

  always_comb begin
    if (raw > V_MAX)      v_o = V_MAX[POT_WIDTH-1:0];
    else if (raw < V_MIN) v_o = V_MIN[POT_WIDTH-1:0];
    else                  v_o = raw[POT_WIDTH-1:0];
  end

endmodule

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: integrates MAC sums, fires at threshold, then
// discards a fixed number of valid steps before integrating again.
module lif_neuron
  import snn_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int POT_WIDTH     = DEF_POT_WIDTH,
  parameter int THRESH        = DEF_THRESH,
  parameter int V_FLOOR       = DEF_V_FLOOR,
  parameter int LEAK_SHIFT    = DEF_LEAK_SHIFT,
  parameter int REFRACT_STEPS = DEF_REFRACT_STEPS
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [WIDTH-1:0]     sumIn,
  input  logic                        sumValid,
  input  logic                        neuronClr,
  output logic                        spikeOut,
  output logic signed [POT_WIDTH-1:0] potOut,
  output logic                        inRefract
);

  localparam logic signed [POT_WIDTH-1:0] THRESH_P     = POT_WIDTH'(THRESH);
  localparam logic [CNT_WIDTH-1:0]        REFRACT_INIT = CNT_WIDTH'(REFRACT_STEPS);
  localparam bit                          HAS_REFRACT  = (REFRACT_STEPS > 0);

  lif_state_e                  state_q, state_d;
  logic signed [POT_WIDTH-1:0] v_q, v_d;
  logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;
  logic                        spike_q, spike_d;

  logic signed [POT_WIDTH-1:0] v_next;
  logic                        fire;

  lif_sat_add #(
    .WIDTH     (WIDTH),
    .POT_WIDTH (POT_WIDTH),
    .LEAK_SHIFT(LEAK_SHIFT),
    .V_FLOOR   (V_FLOOR)
  ) u_sat_add (
    .v_i  (v_q),
    .sum_i(sumIn),
    .v_o  (v_next)
  );

  assign fire = (v_next >= THRESH_P);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_INTEG;
      v_q     <= '0;
      cnt_q   <= '0;
      spike_q <= 1'b0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      cnt_q   <= cnt_d;
      spike_q <= spike_d;
    end
  end

  // NOTE: every combinational output gets a default first so no path
  // through the case/if tree can infer a latch.
  always_comb begin
    state_d = state_q;
    if (neuronClr) begin
      state_d = ST_INTEG;
    end else if (sumValid) begin
      unique case (state_q)
        ST_INTEG:   if (fire && HAS_REFRACT) state_d = ST_REFRACT;
        ST_REFRACT: if (cnt_q <= CNT_WIDTH'(1)) state_d = ST_INTEG;
        default:    state_d = ST_INTEG;
      endcase
    end
  end

  always_comb begin
    v_d     = v_q;
    cnt_d   = cnt_q;
    spike_d = 1'b0;
    if (neuronClr) begin
      v_d   = '0;
      cnt_d = '0;
    end else if (sumValid) begin
      unique case (state_q)
        ST_INTEG: begin
          if (fire) begin
            v_d     = '0;
            spike_d = 1'b1;
            cnt_d   = REFRACT_INIT;
          end else begin
            v_d = v_next;
          end
        end
        ST_REFRACT: begin
          v_d   = '0;
          cnt_d = (cnt_q == '0) ? '0 : cnt_q - CNT_WIDTH'(1);
        end
        default: begin
          v_d   = '0;
          cnt_d = '0;
        end
      endcase
    end
  end

  assign spikeOut  = spike_q;
  assign potOut    = v_q;
  assign inRefract = (state_q == ST_REFRACT);

endmodule

// File: tb/tb_lif_neuron.sv
// Self-checking bench for lif_neuron against an integer reference model,
// with a second instance built without a refractory period.
module tb_lif_neuron;

  localparam int R_MAIN = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic signed [7:0] sum_in, sum_in0;
  logic              sum_valid, sum_valid0, clr, clr0;
  logic              spike, spike0, refr, refr0;
  logic signed [11:0] pot, pot0;

  int n_checks = 0;
  int n_errors = 0;

  int m_v, m_refr;
  bit m_spk;
  int z_v, z_refr;
  bit z_spk;

  always #5 clk = ~clk;

  lif_neuron #(.REFRACT_STEPS(R_MAIN)) dut (
    .clk(clk), .rst(rst), .sumIn(sum_in), .sumValid(sum_valid), .neuronClr(clr),
    .spikeOut(spike), .potOut(pot), .inRefract(refr)
  );

  lif_neuron #(.REFRACT_STEPS(0)) dut0 (
    .clk(clk), .rst(rst), .sumIn(sum_in0), .sumValid(sum_valid0), .neuronClr(clr0),
    .spikeOut(spike0), .potOut(pot0), .inRefract(refr0)
  );

  // Reference: V' = V - floor(V/8) + sum, clamp to [-128, 2047], fire at >= 64,
  // then skip 'rsteps' valid inputs.
  task automatic model_update(inout int v, inout int rleft, output bit spk,
                              input bit valid, input bit c, input int sum, input int rsteps);
    int vn;
    spk = 1'b0;
    if (c) begin
      v = 0;
      rleft = 0;
    end else if (valid) begin
      if (rleft > 0) begin
        rleft = rleft - 1;
        v = 0;
      end else begin
        vn = v - (v >>> 3) + sum;
        if (vn < -128) vn = -128;
        if (vn > 2047) vn = 2047;
        if (vn >= 64) begin
          v = 0;
          spk = 1'b1;
          rleft = rsteps;
        end else begin
          v = vn;
        end
      end
    end
  endtask

  function automatic logic [13:0] pack_exp(int v, bit s, int rleft);
    return {12'(v), s, (rleft > 0)};
  endfunction

  task automatic step(input bit valid, input bit c, input int sum);
    sum_valid = valid;
    clr       = c;
    sum_in    = 8'(sum);
    @(posedge clk);
    #1;
    model_update(m_v, m_refr, m_spk, valid, c, sum, R_MAIN);
    sum_valid = 1'b0;
    clr       = 1'b0;
  endtask

  task automatic step0(input bit valid, input bit c, input int sum);
    sum_valid0 = valid;
    clr0       = c;
    sum_in0    = 8'(sum);
    @(posedge clk);
    #1;
    model_update(z_v, z_refr, z_spk, valid, c, sum, 0);
    sum_valid0 = 1'b0;
    clr0       = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sum_valid = 1'b0; clr = 1'b0; sum_in = '0;
    sum_valid0 = 1'b0; clr0 = 1'b0; sum_in0 = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({pot, spike, refr} !== 14'd0) begin
      n_errors++;
      $display("FAIL reset: got pot=%0d spike=%b refr=%b, expected all 0", pot, spike, refr);
    end
    n_checks++;
    if ({pot0, spike0, refr0} !== 14'd0) begin
      n_errors++;
      $display("FAIL reset_r0: got pot=%0d spike=%b refr=%b, expected all 0", pot0, spike0, refr0);
    end
    rst = 1'b0;
    m_v = 0; m_refr = 0; m_spk = 0;
    z_v = 0; z_refr = 0; z_spk = 0;
  endtask

  task automatic test_ramp();
    int exp_pot[7] = '{20, 38, 54, 0, 0, 0, 20};
    bit exp_spk[7] = '{0, 0, 0, 1, 0, 0, 0};
    bit exp_ref[7] = '{0, 0, 0, 1, 1, 0, 0};
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'b0, 20);
      n_checks++;
      if ({pot, spike, refr} !== {12'(exp_pot[i]), exp_spk[i], exp_ref[i]}) begin
        n_errors++;
        $display("FAIL ramp[%0d]: got pot=%0d spike=%b refr=%b, expected pot=%0d spike=%b refr=%b",
                 i, pot, spike, refr, exp_pot[i], exp_spk[i], exp_ref[i]);
      end
    end
  endtask

  task automatic test_clamp_low();
    step(1'b0, 1'b1, 0);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, -128);
      n_checks++;
      if ({pot, spike, refr} !== pack_exp(m_v, m_spk, m_refr) || pot < -12'sd128) begin
        n_errors++;
        $display("FAIL clamp_low[%0d]: got pot=%0d spike=%b, expected pot=%0d spike=%b",
                 i, pot, spike, m_v, m_spk);
      end
    end
    n_checks++;
    if (pot !== -12'sd128) begin
      n_errors++;
      $display("FAIL clamp_floor: got pot=%0d, expected -128", pot);
    end
  endtask

  task automatic test_hold();
    step(1'b0, 1'b1, 0);
    repeat (3) step(1'b1, 1'b0, 20);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 20);
      n_checks++;
      if ({pot, spike, refr} !== {12'sd54, 1'b0, 1'b0}) begin
        n_errors++;
        $display("FAIL hold[%0d]: got pot=%0d spike=%b refr=%b, expected pot=54 spike=0 refr=0",
                 i, pot, spike, refr);
      end
    end
    step(1'b1, 1'b0, 20);
    n_checks++;
    if ({pot, spike, refr} !== {12'sd0, 1'b1, 1'b1}) begin
      n_errors++;
      $display("FAIL hold_fire: got pot=%0d spike=%b refr=%b, expected pot=0 spike=1 refr=1",
               pot, spike, refr);
    end
  endtask

  task automatic test_clr_in_refract();
    step(1'b0, 1'b1, 0);
    repeat (4) step(1'b1, 1'b0, 20);
    step(1'b1, 1'b1, 100);
    n_checks++;
    if ({pot, spike, refr} !== 14'd0) begin
      n_errors++;
      $display("FAIL clr_refract: got pot=%0d spike=%b refr=%b, expected all 0", pot, spike, refr);
    end
    step(1'b1, 1'b0, 20);
    n_checks++;
    if ({pot, spike, refr} !== {12'sd20, 1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL clr_then_integ: got pot=%0d spike=%b refr=%b, expected pot=20 spike=0 refr=0",
               pot, spike, refr);
    end
  endtask

  task automatic test_async_reset();
    step(1'b0, 1'b1, 0);
    repeat (4) step(1'b1, 1'b0, 20);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({pot, spike, refr} !== 14'd0) begin
      n_errors++;
      $display("FAIL async_reset: got pot=%0d spike=%b refr=%b, expected all 0 before edge",
               pot, spike, refr);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_v = 0; m_refr = 0; m_spk = 0;
    z_v = 0; z_refr = 0; z_spk = 0;
    step(1'b1, 1'b0, 20);
    n_checks++;
    if ({pot, spike, refr} !== {12'sd20, 1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL reset_abandons_refract: got pot=%0d spike=%b refr=%b, expected pot=20 spike=0 refr=0",
               pot, spike, refr);
    end
  endtask

  task automatic test_no_refract();
    for (int i = 0; i < 6; i++) begin
      step0(1'b1, 1'b0, 127);
      n_checks++;
      if ({pot0, spike0, refr0} !== {12'sd0, 1'b1, 1'b0}) begin
        n_errors++;
        $display("FAIL no_refract[%0d]: got pot=%0d spike=%b refr=%b, expected pot=0 spike=1 refr=0",
                 i, pot0, spike0, refr0);
      end
    end
  endtask

  task automatic test_random();
    bit v, c;
    int s;
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 31) == 0);
      s = $urandom_range(0, 255) - 128;
      step(v, c, s);
      n_checks++;
      if ({pot, spike, refr} !== pack_exp(m_v, m_spk, m_refr)) begin
        n_errors++;
        $display("FAIL random[%0d]: got pot=%0d spike=%b refr=%b, expected pot=%0d spike=%b refr=%b",
                 i, pot, spike, refr, m_v, m_spk, m_refr > 0);
      end
    end
    for (int i = 0; i < 200; i++) begin
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 31) == 0);
      s = $urandom_range(0, 127) - 40;
      step0(v, c, s);
      n_checks++;
      if ({pot0, spike0, refr0} !== pack_exp(z_v, z_spk, z_refr)) begin
        n_errors++;
        $display("FAIL random_r0[%0d]: got pot=%0d spike=%b refr=%b, expected pot=%0d spike=%b refr=0",
                 i, pot0, spike0, refr0, z_v, z_spk);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_clamp_low();
    test_hold();
    test_clr_in_refract();
    test_async_reset();
    test_no_refract();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
